// File: rtl/core_id_issue_ctrl.sv
// core_id_issue_ctrl
//   Issue control between the ID and EX stages of an in-order core. It blocks
//   issue on load-use and load-busy hazards, bounds the number of in-flight
//   instructions, and serializes CSR/fence/mret: drain, issue alone, wait
//   until retired.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid / id_ready       ID holds an instruction / it moves to EX now
//   id_rs1, id_rs2, id_rd     register indices of the ID instruction
//   id_rs1_used, id_rs2_used  source operands actually read
//   id_is_ld, id_is_ser       load / serializing instruction
//   ex_valid / ex_ready       issue request to EX / EX accepts
//   ld_done                   outstanding load wrote back (pulse)
//   wb_retire                 one in-flight instruction retired or killed (pulse)
//   flush                     redirect: kills the ID instruction this cycle
//   hazard_stall              issue blocked by a load hazard
//   inflight                  in-flight instruction count
module core_id_issue_ctrl #(
  parameter int INFLIGHT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_rd,
  input  logic                  id_is_ld,
  input  logic                  id_is_ser,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  input  logic                  ld_done,
  input  logic                  wb_retire,
  input  logic                  flush,
  output logic                  hazard_stall,
  output logic [INFLIGHT_W-1:0] inflight
);

  typedef enum logic [1:0] {RUN, DRAIN, SER} state_t;

  state_t state, state_nxt;
  logic   ld_pend;
  logic [4:0] ld_rd;

  logic ld_pend_eff, rs1_hit, rs2_hit, full, idle, xfer, dec;

  always_comb begin
    // A writeback in the same cycle releases the hazard immediately.
    ld_pend_eff  = ld_pend & ~ld_done;
    rs1_hit      = id_rs1_used & (id_rs1 == ld_rd) & (id_rs1 != 5'd0);
    rs2_hit      = id_rs2_used & (id_rs2 == ld_rd) & (id_rs2 != 5'd0);
    // A second load is blocked outright: only one load may be outstanding.
    hazard_stall = ~rst & id_valid & ld_pend_eff & (rs1_hit | rs2_hit | id_is_ld);
    full         = (inflight == {INFLIGHT_W{1'b1}});
    idle         = (inflight == '0);
  end

  // Issue decision and next state. ex_valid never looks at ex_ready.
  always_comb begin
    ex_valid  = 1'b0;
    state_nxt = state;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (id_valid && id_is_ser && !flush) begin
            if (idle && !hazard_stall) begin
              ex_valid = 1'b1;
              if (ex_ready) state_nxt = SER;
            end else begin
              state_nxt = DRAIN;
            end
          end else begin
            ex_valid = id_valid & ~hazard_stall & ~full & ~flush;
          end
        end
        DRAIN: begin
          if (flush) begin
            state_nxt = RUN;
          end else begin
            ex_valid = id_valid & idle & ~hazard_stall;
            if (ex_valid && ex_ready) state_nxt = SER;
          end
        end
        SER: begin
          // The serializing instruction is the only one in flight here.
          if (idle) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign id_ready = ex_valid & ex_ready;
  assign xfer     = id_ready;
  assign dec      = wb_retire & ~idle;  // retire at zero is dropped, no wrap

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      inflight <= '0;
      ld_pend  <= 1'b0;
      ld_rd    <= 5'd0;
    end else begin
      state <= state_nxt;
      if (xfer && !dec)      inflight <= inflight + INFLIGHT_W'(1);
      else if (!xfer && dec) inflight <= inflight - INFLIGHT_W'(1);
      // A newly issued load wins over a writeback of the previous one.
      if (xfer && id_is_ld) begin
        ld_pend <= 1'b1;
        ld_rd   <= id_rd;
      end else if (ld_done) begin
        ld_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_id_issue_ctrl.sv
module tb_core_id_issue_ctrl;
  logic       clk, rst;
  logic       id_valid, id_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_is_ld, id_is_ser;
  logic       ex_valid, ex_ready, ld_done, wb_retire, flush, hazard_stall;
  logic [1:0] inflight;

  int n_run, n_fail;

  core_id_issue_ctrl #(.INFLIGHT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_is_ld(id_is_ld),
    .id_is_ser(id_is_ser), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ld_done(ld_done), .wb_retire(wb_retire), .flush(flush),
    .hazard_stall(hazard_stall), .inflight(inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic ld, input logic ser, input logic [4:0] rs1,
                     input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd);
    id_valid = 1'b1; id_is_ld = ld; id_is_ser = ser;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2; id_rd = rd;
  endtask

  task automatic no_id();
    id_valid = 1'b0; id_is_ld = 1'b0; id_is_ser = 1'b0;
    id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0; id_rs2_used = 1'b0; id_rd = 5'd0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst = 1'b1; ld_done = 1'b0; wb_retire = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
    // reset holds everything low regardless of inputs
    #2;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_ready", id_ready, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_inflight", inflight, 0);
    step(); step();
    chk("rst_inflight_hold", inflight, 0);
    rst = 1'b0;
    no_id();

    // load-use: lw x5; add x6,x5,x1
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5); #2;
    chk("lu_lw_issue", ex_valid, 1);
    chk("lu_lw_ready", id_ready, 1);
    step();
    chk("lu_inflight1", inflight, 1);
    drv(1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6); #2;
    chk("lu_hazard", hazard_stall, 1);
    chk("lu_stall_valid", ex_valid, 0);
    step(); #2;
    chk("lu_hazard2", hazard_stall, 1);
    step();
    ld_done = 1'b1; #2;
    chk("lu_done_hazard", hazard_stall, 0);
    chk("lu_done_issue", ex_valid, 1);
    step();
    ld_done = 1'b0;
    chk("lu_inflight2", inflight, 2);
    no_id(); wb_retire = 1'b1;
    step(); step();
    wb_retire = 1'b0;
    chk("lu_drained", inflight, 0);

    // x0 exemption, then a second load
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0); #2;
    chk("x0_lw_issue", ex_valid, 1);
    step();
    drv(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7); #2;
    chk("x0_hazard", hazard_stall, 0);
    chk("x0_issue", ex_valid, 1);
    step();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8); #2;
    chk("ld2_hazard", hazard_stall, 1);
    chk("ld2_stall", ex_valid, 0);
    step();
    ld_done = 1'b1; #2;
    chk("ld2_done_issue", ex_valid, 1);
    step();
    ld_done = 1'b0;
    chk("ld2_inflight3", inflight, 3);
    // new load's set beat the same-cycle ld_done
    drv(1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9); #2;
    chk("set_wins_hazard", hazard_stall, 1);
    ld_done = 1'b1; wb_retire = 1'b1; #2;
    chk("full_no_haz", hazard_stall, 0);
    chk("full_retire_blocks", ex_valid, 0);
    step();
    ld_done = 1'b0;
    no_id();
    chk("full_retire_dec", inflight, 2);
    step(); step();
    wb_retire = 1'b0;
    chk("x0_drained", inflight, 0);

    // counter bounds
    drv(1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
    step(); step(); step(); #1;
    chk("cnt_max", inflight, 3);
    chk("cnt_full_valid", ex_valid, 0);
    wb_retire = 1'b1; #1;
    chk("cnt_full_retire", ex_valid, 0);
    step();
    chk("cnt_dec", inflight, 2);
    #1;
    chk("cnt_xfer_retire_valid", ex_valid, 1);
    step();
    chk("cnt_xfer_retire_hold", inflight, 2);
    no_id();
    step(); step(); step();
    wb_retire = 1'b0;
    chk("cnt_no_wrap", inflight, 0);

    // serialize: two in flight, csrrw arrives
    drv(1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
    step(); step();
    chk("ser_pre_inflight", inflight, 2);
    drv(1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4); #2;
    chk("ser_run_block", ex_valid, 0);
    step();
    wb_retire = 1'b1; #2;
    chk("ser_drain_block1", ex_valid, 0);
    step(); #2;
    chk("ser_drain_block2", ex_valid, 0);
    step();
    wb_retire = 1'b0; #2;
    chk("ser_drain_issue", ex_valid, 1);
    chk("ser_drain_ready", id_ready, 1);
    step();
    chk("ser_inflight1", inflight, 1);
    drv(1'b0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3); #2;
    chk("ser_hold1", ex_valid, 0);
    step(); #2;
    chk("ser_hold2", ex_valid, 0);
    wb_retire = 1'b1;
    step();
    wb_retire = 1'b0; #2;
    chk("ser_hold_idle", ex_valid, 0);
    step(); #2;
    chk("ser_back_run", ex_valid, 1);
    step();
    no_id(); wb_retire = 1'b1;
    step();
    wb_retire = 1'b0;
    chk("ser_done_inflight", inflight, 0);

    // flush while a fence waits in DRAIN
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
    step();
    drv(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0); #2;
    chk("fl_fence_block", ex_valid, 0);
    step();
    flush = 1'b1; #2;
    chk("fl_drain_block", ex_valid, 0);
    step();
    flush = 1'b0;
    chk("fl_inflight_kept", inflight, 1);
    ex_ready = 1'b0;
    drv(1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd5); #2;
    chk("fl_ldpend_kept", hazard_stall, 1);
    drv(1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd5); #2;
    chk("fl_in_run", ex_valid, 1);
    chk("fl_no_ready", id_ready, 0);
    flush = 1'b1; #1;
    chk("fl_run_kill", ex_valid, 0);
    flush = 1'b0; ex_ready = 1'b1;
    no_id(); ld_done = 1'b1; wb_retire = 1'b1;
    step();
    ld_done = 1'b0; wb_retire = 1'b0;
    chk("fl_clean", inflight, 0);

    // reset from SER with a pending load
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9);
    step();
    no_id(); wb_retire = 1'b1;
    step();
    wb_retire = 1'b0;
    drv(1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0); #2;
    chk("rs_ser_direct", ex_valid, 1);
    step();
    drv(1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd6); #2;
    chk("rs_in_ser", ex_valid, 0);
    chk("rs_pend_haz", hazard_stall, 1);
    rst = 1'b1; #1;
    chk("rs_async_valid", ex_valid, 0);
    chk("rs_async_ready", id_ready, 0);
    chk("rs_async_haz", hazard_stall, 0);
    chk("rs_async_inflight", inflight, 0);
    step();
    rst = 1'b0; #2;
    chk("rs_after_haz", hazard_stall, 0);
    chk("rs_after_issue", ex_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // hard bound on runtime
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/core_id_issue_ctrl.md
CORE_ID_ISSUE_CTRL -- requirements
Module: core_id_issue_ctrl

Interface
REQ-001 SHALL have parameter INFLIGHT_W, default 2, width of the in-flight instruction counter; maximum count = 2^INFLIGHT_W-1.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  ID stage holds a decoded instruction.
REQ-005 SHALL have port id_ready  output  1  ID instruction transferred to EX this cycle.
REQ-006 SHALL have port id_rs1 / id_rs2  input  5 each  source register indices.
REQ-007 SHALL have port id_rs1_used / id_rs2_used  input  1 each  source actually read.
REQ-008 SHALL have port id_rd  input  5  destination register index.
REQ-009 SHALL have port id_is_ld  input  1  instruction is a load (any width).
REQ-010 SHALL have port id_is_ser  input  1  serializing instruction (any csrrw/s/c/wi/si/ci, fence, mret).
REQ-011 SHALL have port ex_valid  output  1  issue request to EX.
REQ-012 SHALL have port ex_ready  input  1  EX accepts this cycle.
REQ-013 SHALL have port ld_done  input  1  pulse: outstanding load has written back.
REQ-014 SHALL have port wb_retire  input  1  pulse: one in-flight instruction retired or was killed.
REQ-015 SHALL have port flush  input  1  branch/trap redirect; kills the ID instruction this cycle.
REQ-016 SHALL have port hazard_stall  output  1  issue blocked by load-use or load-busy hazard.
REQ-017 SHALL have port inflight  output  INFLIGHT_W  current in-flight count.

Function
REQ-018 SHALL implement FSM states RUN, DRAIN, SER; reset state RUN.
REQ-019 SHALL hold ld_pend (1 bit) and ld_rd (5 bits) scoreboard; reset 0/0.
REQ-020 SHALL define ld_pend_eff = ld_pend & ~ld_done (same-cycle writeback releases the hazard).
REQ-021 SHALL assert hazard_stall when id_valid & ld_pend_eff & ((id_rs1_used & id_rs1==ld_rd & id_rs1!=0) | (id_rs2_used & id_rs2==ld_rd & id_rs2!=0) | id_is_ld).
REQ-022 SHALL define full = (inflight == 2^INFLIGHT_W-1); retire in the same cycle does not unblock.
REQ-023 RUN, non-serializing: ex_valid = id_valid & ~hazard_stall & ~full & ~flush.
REQ-024 RUN, id_is_ser & id_valid & ~flush: if inflight==0 and ~hazard_stall, ex_valid=1 and on transfer go to SER; else ex_valid=0 and go to DRAIN.
REQ-025 DRAIN: ex_valid = id_valid & (inflight==0) & ~hazard_stall & ~flush; on transfer go to SER; on flush go to RUN.
REQ-026 SER: ex_valid=0; go to RUN when inflight==0 (serializing instruction retired); flush does not leave SER.
REQ-027 SHALL drive id_ready = ex_valid & ex_ready, combinationally; ex_valid SHALL not depend on ex_ready.
REQ-028 On transfer of a load, SHALL set ld_pend=1, ld_rd=id_rd (including rd=x0); set wins over same-cycle ld_done.
REQ-029 ld_done without same-cycle load transfer SHALL clear ld_pend.
REQ-030 inflight SHALL +1 on transfer, -1 on wb_retire, hold when both; wb_retire at 0 SHALL be ignored (no wrap).
REQ-031 flush SHALL not modify inflight or the scoreboard; killed instructions report through wb_retire.
REQ-032 Outputs hazard_stall, ex_valid, id_ready SHALL be combinational from state and inputs, no extra latency; issue latency 0 cycles.

Reset
REQ-033 While rst=1: state=RUN, inflight=0, ld_pend=0, ld_rd=0, ex_valid=0, id_ready=0, hazard_stall=0, regardless of inputs.
REQ-034 Reset asserted mid-DRAIN or mid-SER SHALL return to RUN immediately; first issue possible the cycle after rst deasserts.

Verification
REQ-035 Load-use: issue lw x5, next add x6,x5,x1 with rs1_used -> hazard_stall=1, ex_valid=0 until ld_done cycle, where ex_valid=1.
REQ-036 x0 exemption: lw x0 pending, add x7,x0,x0 -> hazard_stall=0, issues at once; second load -> stalls until ld_done.
REQ-037 Serialize: inflight=2, csrrw arrives -> DRAIN, ex_valid=0; two wb_retire -> inflight=0, issue, SER; next instruction waits for one wb_retire -> RUN.
REQ-038 Counter bounds (INFLIGHT_W=2): 3 transfers no retire -> inflight=3, ex_valid=0; transfer+retire same cycle -> unchanged; wb_retire at 0 -> stays 0.
REQ-039 Flush: DRAIN with fence waiting, flush=1 -> ex_valid=0, next state RUN, inflight and ld_pend unchanged.
REQ-040 Reset: rst asserted in SER with inflight=1, ld_pend=1 -> all outputs 0, state RUN, after deassert a valid add issues the same cycle.
